// File: rtl/lyra2_din_fifo.sv
// lyra2_din_fifo: input-side FIFO for the Lyra2 top level.
// Buffers host/DMA words and serves the i_d_in / i_d_in_rdy / o_d_in_rd
// read side with first-word-fall-through data and a "not almost empty" flag.
// Optional feature macro: LYRA2_FIFO_ERR_FLAGS_EN enables the sticky
// overflow/underflow flags and i_clr_err; otherwise those flags read 0.

package lyra2_top_pkg;
   localparam int LYRA2_INPUT_DATA_WIDTH = 32;
   localparam int LYRA2_PIPELINE_STAGES  = 4;
endpackage

module lyra2_din_fifo
   import lyra2_top_pkg::*;
#(
   parameter int DATA_WIDTH   = LYRA2_INPUT_DATA_WIDTH,
   parameter int DEPTH        = 64,
   parameter int AE_THRESHOLD = LYRA2_PIPELINE_STAGES,
   parameter int AF_MARGIN    = 2
) (
   input  logic                       i_clk,
   input  logic                       i_reset_n,
   input  logic [DATA_WIDTH-1:0]      i_wr_data,
   input  logic                       i_wr,
   output logic                       o_wr_rdy,
   output logic                       o_full,
   output logic [DATA_WIDTH-1:0]      o_d_out,
   output logic                       o_d_out_rdy,
   input  logic                       i_rd,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic                       o_overflow,
   output logic                       o_underflow,
   input  logic                       i_clr_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AE_C    = CW'(AE_THRESHOLD);
   localparam logic [CW-1:0] AF_C    = CW'(DEPTH - AF_MARGIN);

   // Parameter sanity: a non-power-of-two depth would break natural pointer wrap.
   if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("lyra2_din_fifo: DEPTH must be a power of two and at least 4");
   end
   if (AE_THRESHOLD >= DEPTH) begin : g_bad_ae
      $error("lyra2_din_fifo: AE_THRESHOLD must be below DEPTH");
   end

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [CW-1:0]         count;
   logic [CW-1:0]         count_nxt;
   logic                  wr_acc;
   logic                  rd_acc;

   // Accept logic: a full FIFO still takes a write when a read frees a slot
   // in the same cycle; a read at empty never bypasses a concurrent write.
   always_comb begin
      rd_acc    = i_rd && (count != '0);
      wr_acc    = i_wr && ((count != DEPTH_C) || rd_acc);
      count_nxt = count;
      case ({wr_acc, rd_acc})
         2'b10:   count_nxt = count + CW'(1);
         2'b01:   count_nxt = count - CW'(1);
         default: count_nxt = count;
      endcase
   end

   // Storage array; cleared on reset so the head word reads 0 afterwards.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_acc) begin
         mem[wr_ptr] <= i_wr_data;
      end
   end

   // Read and write pointers; they wrap modulo DEPTH on their own.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_acc) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
      end
   end

   // Occupancy and status flags, all registered from the next-state count
   // so they line up with o_count in the same cycle.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         count       <= '0;
         o_d_out_rdy <= 1'b0;
         o_full      <= 1'b0;
         o_wr_rdy    <= 1'b1;
      end else begin
         count       <= count_nxt;
         o_d_out_rdy <= (count_nxt > AE_C);
         o_full      <= (count_nxt == DEPTH_C);
         o_wr_rdy    <= (count_nxt < AF_C);
      end
   end

   assign o_count = count;
   assign o_d_out = mem[rd_ptr];

`ifdef LYRA2_FIFO_ERR_FLAGS_EN
   logic ovf_set;
   logic udf_set;

   assign ovf_set = i_wr && !wr_acc;
   assign udf_set = i_rd && !rd_acc;

   // Sticky error flags; a new error in the same cycle as a clear wins.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_overflow  <= 1'b0;
         o_underflow <= 1'b0;
      end else begin
         if (ovf_set) begin
            o_overflow <= 1'b1;
         end else if (i_clr_err) begin
            o_overflow <= 1'b0;
         end
         if (udf_set) begin
            o_underflow <= 1'b1;
         end else if (i_clr_err) begin
            o_underflow <= 1'b0;
         end
      end
   end
`else
   logic unused_clr_err;

   assign unused_clr_err = i_clr_err;
   assign o_overflow     = 1'b0;
   assign o_underflow    = 1'b0;
`endif

endmodule

// File: tb/tb_lyra2_din_fifo.sv
// Directed bench for lyra2_din_fifo with a queue scoreboard for data order
// and a small occupancy/flag model.
module tb_lyra2_din_fifo;

   localparam int DW    = 32;
   localparam int DEPTH = 64;
   localparam int AE    = 4;
   localparam int AFM   = 2;
`ifdef LYRA2_FIFO_ERR_FLAGS_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic                    i_clk;
   logic                    i_reset_n;
   logic [DW-1:0]           i_wr_data;
   logic                    i_wr;
   logic                    o_wr_rdy;
   logic                    o_full;
   logic [DW-1:0]           o_d_out;
   logic                    o_d_out_rdy;
   logic                    i_rd;
   logic [$clog2(DEPTH):0]  o_count;
   logic                    o_overflow;
   logic                    o_underflow;
   logic                    i_clr_err;

   lyra2_din_fifo #(
      .DATA_WIDTH   (DW),
      .DEPTH        (DEPTH),
      .AE_THRESHOLD (AE),
      .AF_MARGIN    (AFM)
   ) dut (
      .i_clk       (i_clk),
      .i_reset_n   (i_reset_n),
      .i_wr_data   (i_wr_data),
      .i_wr        (i_wr),
      .o_wr_rdy    (o_wr_rdy),
      .o_full      (o_full),
      .o_d_out     (o_d_out),
      .o_d_out_rdy (o_d_out_rdy),
      .i_rd        (i_rd),
      .o_count     (o_count),
      .o_overflow  (o_overflow),
      .o_underflow (o_underflow),
      .i_clr_err   (i_clr_err)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int unsigned   vectors     = 0;
   int unsigned   miscompares = 0;
   logic [DW-1:0] sb[$];
   int            m_count = 0;
   bit            m_ovf   = 1'b0;
   bit            m_udf   = 1'b0;
   int            rd_seen = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_status();
      chk("count",     32'(o_count),     32'(m_count));
      chk("d_out_rdy", 32'(o_d_out_rdy), 32'(m_count > AE));
      chk("full",      32'(o_full),      32'(m_count == DEPTH));
      chk("wr_rdy",    32'(o_wr_rdy),    32'(m_count < DEPTH - AFM));
      chk("overflow",  32'(o_overflow),  32'(m_ovf));
      chk("underflow", 32'(o_underflow), 32'(m_udf));
      if (sb.size() > 0) chk("head", o_d_out, sb[0]);
   endtask

   // One clock cycle: drive, predict, consume head on an accepted read.
   task automatic cycle(input logic wr, input logic [DW-1:0] d, input logic rd, input logic clr);
      bit rd_ok;
      bit wr_ok;
      logic [DW-1:0] exp;
      i_wr      = wr;
      i_wr_data = d;
      i_rd      = rd;
      i_clr_err = clr;
      rd_ok = rd && (m_count > 0);
      wr_ok = wr && ((m_count < DEPTH) || rd_ok);
      if (rd_ok) begin
         exp = sb.pop_front();
         chk("rd_data", o_d_out, exp);
         rd_seen++;
      end
      if (wr_ok) sb.push_back(d);
      m_count = m_count + int'(wr_ok) - int'(rd_ok);
      if (ERR_EN) begin
         if (wr && !wr_ok) m_ovf = 1'b1;
         else if (clr)     m_ovf = 1'b0;
         if (rd && !rd_ok) m_udf = 1'b1;
         else if (clr)     m_udf = 1'b0;
      end
      @(posedge i_clk);
      #1;
      i_wr      = 1'b0;
      i_rd      = 1'b0;
      i_clr_err = 1'b0;
      check_status();
   endtask

   initial begin
      int base;
      int nxt;
      i_reset_n = 1'b0;
      i_wr = 1'b0; i_rd = 1'b0; i_clr_err = 1'b0; i_wr_data = '0;
      #12;
      chk("rst_count",  32'(o_count),     32'd0);
      chk("rst_rdy",    32'(o_d_out_rdy), 32'd0);
      chk("rst_full",   32'(o_full),      32'd0);
      chk("rst_wr_rdy", 32'(o_wr_rdy),    32'd1);
      chk("rst_ovf",    32'(o_overflow),  32'd0);
      chk("rst_udf",    32'(o_underflow), 32'd0);
      chk("rst_d_out",  o_d_out,          32'd0);
      @(negedge i_clk);
      i_reset_n = 1'b1;
      @(posedge i_clk);
      #1;

      // First write falls through to the head next cycle.
      cycle(1'b1, 32'hA5, 1'b0, 1'b0);
      chk("first_count", 32'(o_count), 32'd1);
      chk("first_head",  o_d_out,      32'hA5);
      chk("first_rdy",   32'(o_d_out_rdy), 32'd0);

      // Almost-empty boundary.
      for (int i = 1; i < 5; i++) cycle(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
      chk("ae_rise", 32'(o_d_out_rdy), 32'd1);
      cycle(1'b0, '0, 1'b1, 1'b0);
      chk("ae_fall",  32'(o_d_out_rdy), 32'd0);
      chk("ae_count", 32'(o_count),     32'd4);
      for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0);

      // Fill, overflow, then simultaneous write/read at full.
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'h2000 + 32'(i), 1'b0, 1'b0);
      cycle(1'b1, 32'h1234, 1'b0, 1'b0);
      chk("ovf_full",  32'(o_full),     32'd1);
      chk("ovf_count", 32'(o_count),    32'd64);
      chk("ovf_flag",  32'(o_overflow), 32'(ERR_EN));
      cycle(1'b1, 32'h5678, 1'b1, 1'b0);
      chk("full_rw_count", 32'(o_count), 32'd64);
      chk("full_rw_head",  o_d_out,      32'h2001);
      cycle(1'b0, '0, 1'b0, 1'b1);
      chk("ovf_clr", 32'(o_overflow), 32'd0);
      while (m_count > 0) cycle(1'b0, '0, 1'b1, 1'b0);

      // Wrap-around stream with random gaps.
      base = rd_seen;
      nxt  = 0;
      for (int cyc = 0; cyc < 4000 && (rd_seen - base) < 200; cyc++) begin
         logic w;
         logic r;
         w = (nxt < 200) && (m_count < DEPTH) && ($urandom_range(0, 3) != 0);
         r = (m_count > 0) && ($urandom_range(0, 2) != 0);
         cycle(w, 32'(nxt), r, 1'b0);
         if (w) nxt++;
      end
      chk("wrap_done", 32'(rd_seen - base), 32'd200);
      chk("wrap_ovf",  32'(o_overflow),     32'd0);
      chk("wrap_udf",  32'(o_underflow),    32'd0);

      // Underflow at empty with a simultaneous write; the write still lands.
      cycle(1'b1, 32'h77, 1'b1, 1'b0);
      chk("udf_flag",  32'(o_underflow), 32'(ERR_EN));
      chk("udf_count", 32'(o_count),     32'd1);
      chk("udf_head",  o_d_out,          32'h77);
      cycle(1'b0, '0, 1'b0, 1'b1);
      chk("udf_clr", 32'(o_underflow), 32'd0);
      cycle(1'b0, '0, 1'b1, 1'b0);
      // New error in the same cycle as a clear: set wins.
      cycle(1'b0, '0, 1'b1, 1'b1);
      chk("set_wins", 32'(o_underflow), 32'(ERR_EN));
      cycle(1'b0, '0, 1'b0, 1'b1);

      // Asynchronous reset between edges at count 30.
      for (int i = 0; i < 30; i++) cycle(1'b1, 32'h3000 + 32'(i), 1'b0, 1'b0);
      chk("pre_rst_count", 32'(o_count), 32'd30);
      #2;
      i_reset_n = 1'b0;
      #1;
      chk("arst_count", 32'(o_count),     32'd0);
      chk("arst_rdy",   32'(o_d_out_rdy), 32'd0);
      chk("arst_d_out", o_d_out,          32'd0);
      sb.delete();
      m_count = 0;
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
      @(negedge i_clk);
      i_reset_n = 1'b1;
      @(posedge i_clk);
      #1;
      check_status();
      cycle(1'b1, 32'hBEEF, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
